// File: rtl/lau_pkg.sv
// Shared arithmetic-unit definitions: implementation speed grades for the LAU building blocks.
package lau_pkg;

    typedef enum logic [1:0] {
        SMALL    = 2'd0,
        BALANCED = 2'd1,
        FAST     = 2'd2
    } speed_e;

endpackage

// File: rtl/Inc.sv
// Combinational incrementer z = a + 1; co is set when a is all-ones.
// The speed grade only selects the carry structure, never the function.
module Inc #(
    parameter int              width = 8,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic [width-1:0] a,
    output logic [width-1:0] z,
    output logic             co
);

    generate
        if (speed == lau_pkg::SMALL) begin : g_ripple
            logic [width:0] c;
            assign c[0] = 1'b1;
            for (genvar i = 0; i < width; i++) begin : g_bit
                assign z[i]   = a[i] ^ c[i];
                assign c[i+1] = a[i] & c[i];
            end
            assign co = c[width];
        end else if (speed == lau_pkg::BALANCED) begin : g_prefix
            // bit i toggles exactly when every lower bit is one
            logic [width-1:0] ones_below;
            assign ones_below[0] = 1'b1;
            for (genvar i = 1; i < width; i++) begin : g_bit
                assign ones_below[i] = &a[i-1:0];
            end
            assign z  = a ^ ones_below;
            assign co = &a;
        end else begin : g_fast
            assign {co, z} = {1'b0, a} + {{width{1'b0}}, 1'b1};
        end
    endgenerate

endmodule

// File: rtl/inc_share_ctrl.sv
// Round-robin sharing of one Inc instance among nreq requesters, with a single registered result slot.
// Build option: define INC_SHARE_CTRL_SATURATE_EN to saturate an all-ones operand instead of wrapping to 0.
module inc_share_ctrl #(
    parameter int              width = 8,
    parameter int              nreq  = 4,
    parameter lau_pkg::speed_e speed = lau_pkg::FAST
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [nreq-1:0]                             req_valid_i,
    input  logic [nreq*width-1:0]                       req_op_i,
    output logic [nreq-1:0]                             req_ready_o,
    output logic                                        rsp_valid_o,
    input  logic                                        rsp_ready_i,
    output logic [width-1:0]                            rsp_op_o,
    output logic [((nreq > 1) ? $clog2(nreq) : 1)-1:0] rsp_id_o,
    output logic                                        rsp_ovf_o
);

    localparam int idw = (nreq > 1) ? $clog2(nreq) : 1;

    logic             slot_free;
    logic             req_any;
    logic             grant;
    logic [idw-1:0]   gnt_idx;
    logic [width-1:0] op_sel;
    logic [width-1:0] inc_z;
    logic             inc_co;

    logic             rsp_vld_p1;
    logic [width-1:0] rsp_op_p1;
    logic [idw-1:0]   rsp_id_p1;
    logic             rsp_ovf_p1;

    function automatic logic [width-1:0] inc_result(input logic [width-1:0] z, input logic co);
`ifdef INC_SHARE_CTRL_SATURATE_EN
        return co ? {width{1'b1}} : z;
`else
        return co ? {width{1'b0}} : z;
`endif
    endfunction

    assign slot_free = !rsp_vld_p1 || rsp_ready_i;
    assign req_any   = |req_valid_i;
    // rst_ni gates the grant so nothing is accepted while reset is asserted
    assign grant     = rst_ni && slot_free && req_any;

    generate
        if (nreq == 1) begin : g_single
            assign gnt_idx = '0;
        end else begin : g_rr
            logic [idw-1:0] rr_ptr;
            logic           found;
            int             cand;

            always_comb begin
                gnt_idx = rr_ptr;
                found   = 1'b0;
                cand    = 0;
                for (int k = 0; k < nreq; k++) begin
                    cand = int'(rr_ptr) + k;
                    if (cand >= nreq) cand = cand - nreq;
                    if (!found && req_valid_i[idw'(cand)]) begin
                        found   = 1'b1;
                        gnt_idx = idw'(cand);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    rr_ptr <= '0;
                end else if (grant) begin
                    rr_ptr <= (int'(gnt_idx) == nreq - 1) ? '0 : gnt_idx + 1'b1;
                end
            end
        end
    endgenerate

    for (genvar i = 0; i < nreq; i++) begin : g_ready
        assign req_ready_o[i] = grant && (gnt_idx == idw'(i));
    end

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < nreq; i++) begin
            if (int'(gnt_idx) == i) op_sel = req_op_i[i*width +: width];
        end
    end

    Inc #(
        .width (width),
        .speed (speed)
    ) u_inc (
        .a  (op_sel),
        .z  (inc_z),
        .co (inc_co)
    );

    // stage p1: result slot, reloaded on every grant so back-to-back transfers have no bubble
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_vld_p1 <= 1'b0;
            rsp_op_p1  <= '0;
            rsp_id_p1  <= '0;
            rsp_ovf_p1 <= 1'b0;
        end else if (grant) begin
            rsp_vld_p1 <= 1'b1;
            rsp_op_p1  <= inc_result(inc_z, inc_co);
            rsp_id_p1  <= gnt_idx;
            rsp_ovf_p1 <= inc_co;
        end else if (rsp_ready_i) begin
            rsp_vld_p1 <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_vld_p1;
    assign rsp_op_o    = rsp_op_p1;
    assign rsp_id_o    = rsp_id_p1;
    assign rsp_ovf_o   = rsp_ovf_p1;

endmodule

// File: tb/tb_inc_share_ctrl.sv
// Bench for inc_share_ctrl: three instances (one per speed grade) in lockstep against a reference model and scoreboard.
module tb_inc_share_ctrl;

`ifdef INC_SHARE_CTRL_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_ni;
    logic [3:0]  req_valid_i;
    logic [31:0] req_op_i;
    logic        rsp_ready_i;

    logic [3:0]  rdy_o [3];
    logic        vld_o [3];
    logic [7:0]  op_o  [3];
    logic [1:0]  id_o  [3];
    logic        ovf_o [3];

    always #5 clk = ~clk;

    for (genvar s = 0; s < 3; s++) begin : g_dut
        inc_share_ctrl #(
            .width (8),
            .nreq  (4),
            .speed (lau_pkg::speed_e'(s))
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_ni),
            .req_valid_i (req_valid_i),
            .req_op_i    (req_op_i),
            .req_ready_o (rdy_o[s]),
            .rsp_valid_o (vld_o[s]),
            .rsp_ready_i (rsp_ready_i),
            .rsp_op_o    (op_o[s]),
            .rsp_id_o    (id_o[s]),
            .rsp_ovf_o   (ovf_o[s])
        );
    end

    typedef struct packed {
        logic [7:0] op;
        logic [1:0] id;
        logic       ovf;
    } rsp_t;

    rsp_t       sb[$];
    int         ptr_m = 0;
    int         nchk  = 0;
    int         nerr  = 0;
    logic [3:0] last_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic rsp_t expect_rsp(input logic [7:0] op, input int id);
        rsp_t r;
        r.ovf = (op == 8'hFF);
        r.op  = r.ovf ? (SAT ? 8'hFF : 8'h00) : op + 8'd1;
        r.id  = id[1:0];
        return r;
    endfunction

    task automatic chk_out(input string tag, input logic vld, input logic [7:0] op,
                           input logic [1:0] id, input logic ovf);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("%s_vld[%0d]", tag, s), vld_o[s], vld);
            chk($sformatf("%s_op[%0d]", tag, s), op_o[s], op);
            chk($sformatf("%s_id[%0d]", tag, s), id_o[s], id);
            chk($sformatf("%s_ovf[%0d]", tag, s), ovf_o[s], ovf);
        end
    endtask

    task automatic chk_vld(input string tag, input logic vld);
        for (int s = 0; s < 3; s++) chk($sformatf("%s_vld[%0d]", tag, s), vld_o[s], vld);
    endtask

    // Called just after a rising edge; drives one cycle, checks at the falling edge, advances the model.
    task automatic step(input logic rst_n, input logic [3:0] vld, input logic [31:0] ops, input logic rdy);
        logic       gnt;
        int         g;
        int         c;
        logic [3:0] exp_rdy;
        rst_ni      = rst_n;
        req_valid_i = vld;
        req_op_i    = ops;
        rsp_ready_i = rdy;
        gnt = 1'b0;
        g   = 0;
        if (rst_n && ((sb.size() == 0) || rdy)) begin
            for (int k = 0; k < 4; k++) begin
                c = (ptr_m + k) % 4;
                if (!gnt && vld[c]) begin
                    gnt = 1'b1;
                    g   = c;
                end
            end
        end
        exp_rdy = '0;
        if (gnt) exp_rdy[g] = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("sb_ready[%0d]", s), rdy_o[s], exp_rdy);
            chk($sformatf("sb_valid[%0d]", s), vld_o[s], sb.size() != 0);
            if (sb.size() != 0) begin
                chk($sformatf("sb_op[%0d]", s), op_o[s], sb[0].op);
                chk($sformatf("sb_id[%0d]", s), id_o[s], sb[0].id);
                chk($sformatf("sb_ovf[%0d]", s), ovf_o[s], sb[0].ovf);
            end
        end
        last_rdy = rdy_o[0];
        if (rst_n && sb.size() != 0 && rdy) void'(sb.pop_front());
        if (gnt) sb.push_back(expect_rsp(ops[g*8 +: 8], g));
        @(posedge clk);
        #1;
        if (!rst_n) begin
            sb.delete();
            ptr_m = 0;
        end else if (gnt) begin
            ptr_m = (g + 1) % 4;
        end
    endtask

    initial begin
        logic [31:0] rops;
        rst_ni      = 1'b0;
        req_valid_i = '0;
        req_op_i    = '0;
        rsp_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);

        // single request
        step(1'b1, 4'b0001, pk(8'h3C, 8'h00, 8'h00, 8'h00), 1'b1);
        chk("single_rdy", last_rdy, 4'b0001);
        chk_out("single", 1'b1, 8'h3D, 2'd0, 1'b0);
        step(1'b1, 4'b0000, '0, 1'b1);
        chk_vld("single_drop", 1'b0);

        // round robin from a fresh pointer
        step(1'b0, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 4'b1111, pk(8'h00, 8'h10, 8'h20, 8'h30), 1'b1);
            chk("rr_rdy", last_rdy, 32'(1 << (i % 4)));
            chk_out("rr", 1'b1, 8'((i % 4) * 16 + 1), 2'(i % 4), 1'b0);
        end

        // backpressure
        step(1'b1, 4'b0001, pk(8'h05, 8'h41, 8'h62, 8'h00), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 4'b0110, pk(8'h05, 8'h41, 8'h62, 8'h00), 1'b0);
            chk("bp_rdy", last_rdy, 4'b0000);
            chk_out("bp_hold", 1'b1, 8'h06, 2'd0, 1'b0);
        end
        step(1'b1, 4'b0110, pk(8'h05, 8'h41, 8'h62, 8'h00), 1'b1);
        chk("bp_release_rdy", last_rdy, 4'b0010);
        chk_out("bp_new", 1'b1, 8'h42, 2'd1, 1'b0);
        step(1'b1, 4'b0000, '0, 1'b1);

        // overflow boundary (pointer now at 2)
        step(1'b1, 4'b0100, pk(8'h00, 8'h00, 8'hFF, 8'h00), 1'b1);
        chk_out("ovf_ff", 1'b1, SAT ? 8'hFF : 8'h00, 2'd2, 1'b1);
        step(1'b0 | 1'b1, 4'b0100, pk(8'h00, 8'h00, 8'hFE, 8'h00), 1'b1);
        chk_out("ovf_fe", 1'b1, 8'hFF, 2'd2, 1'b0);
        step(1'b1, 4'b0000, '0, 1'b1);

        // reset mid-stream with pointer at 2 and a held result
        step(1'b0, 4'b0000, '0, 1'b1);
        step(1'b1, 4'b0001, pk(8'h11, 8'h22, 8'h33, 8'h44), 1'b1);
        step(1'b1, 4'b0010, pk(8'h11, 8'h22, 8'h33, 8'h44), 1'b1);
        chk_out("pre_rst", 1'b1, 8'h23, 2'd1, 1'b0);
        step(1'b0, 4'b1111, pk(8'h11, 8'h22, 8'h33, 8'h44), 1'b1);
        chk("rst_rdy", last_rdy, 4'b0000);
        chk_out("rst_clear", 1'b0, 8'h00, 2'd0, 1'b0);
        step(1'b1, 4'b1111, pk(8'h11, 8'h22, 8'h33, 8'h44), 1'b1);
        chk("post_rst_rdy", last_rdy, 4'b0001);
        chk_out("post_rst", 1'b1, 8'h12, 2'd0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rops = $urandom;
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) rops[b*8 +: 8] = 8'hFF;
            end
            step($urandom_range(0, 49) != 0, 4'($urandom_range(0, 15)), rops, $urandom_range(0, 3) != 0);
        end

        // drain
        step(1'b1, 4'b0000, '0, 1'b1);
        step(1'b1, 4'b0000, '0, 1'b1);
        chk_vld("drain", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
